// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding, default tick counts and counter sizing for the key classifier
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  localparam int DEF_DEBOUNCE_TICKS = 200;
  localparam int DEF_LONG_TICKS     = 10000;
  localparam int DEF_REPEAT_TICKS   = 2000;

  // Width of a counter that must hold 0..ticks-1; never narrower than one bit.
  function automatic int cnt_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_filter.sv
// rtl/key_debounce_filter.sv - two-flop synchronizer plus consecutive-sample debounce filter
module key_debounce_filter
  import key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int DW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_TICKS - 1);

  logic          sync_a;
  logic          sync_b;
  logic [DW-1:0] cnt;

  // The level flips on the DEBOUNCE_TICKS-th consecutive sample that disagrees with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt >= DEB_MAX) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - classifies debounced presses into short, long and auto-repeat pulses
// Define KEY_AUTOREPEAT_EN to build the repeat counter; otherwise repeat_pulse is tied low.
module key_press_classifier
  import key_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  localparam int LW = cnt_width(LONG_TICKS);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS - 1);

  key_state_t    state;
  key_state_t    state_next;
  logic [LW-1:0] press_cnt;
  logic [LW-1:0] press_cnt_next;
  logic          level;
  logic          level_q;
  logic          rise;
  logic          fall;
  logic          short_next;
  logic          long_next;

  key_debounce_filter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
  ) u_filter (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (key_in),
    .level(level)
  );

  assign rise     = level & ~level_q;
  assign fall     = ~level & level_q;
  assign key_held = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      press_cnt   <= '0;
      level_q     <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      state       <= state_next;
      press_cnt   <= press_cnt_next;
      level_q     <= level;
      short_pulse <= short_next;
      long_pulse  <= long_next;
    end
  end

  // The long threshold is tested before release so a coincident release yields long only.
  always_comb begin
    state_next     = state;
    press_cnt_next = '0;
    short_next     = 1'b0;
    long_next      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_next = PRESSED;
      end
      PRESSED: begin
        press_cnt_next = (press_cnt == LONG_MAX) ? press_cnt : press_cnt + 1'b1;
        if (press_cnt == LONG_MAX) begin
          long_next  = 1'b1;
          state_next = fall ? IDLE : HELD;
        end else if (fall) begin
          short_next = 1'b1;
          state_next = IDLE;
        end
      end
      HELD: begin
        if (fall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cnt_width(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_cnt;

  // Starts from 0 in the cycle long_pulse is high, so the first repeat lands REPEAT_TICKS later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == HELD && !fall) begin
        if (rep_cnt >= REP_MAX) begin
          rep_cnt      <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_cnt <= '0;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - self-checking bench for key_press_classifier (DEBOUNCE=4, LONG=20, REPEAT=5)
module tb_key_press_classifier;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic key;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  key_press_classifier #(
    .DEBOUNCE_TICKS(D),
    .LONG_TICKS    (L),
    .REPEAT_TICKS  (R)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_in      (key),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .repeat_pulse(repeat_pulse),
    .key_held    (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last D synchronized samples all disagree with it;
  // a press lasting d key_held cycles from rise h is short (at release) if d < L, otherwise
  // long at h+L with repeats at h+L+k*R while still held.
  int m_cyc;
  int m_h;
  bit m_lvl, m_kh, m_short, m_long, m_rep;
  bit pipe[$];
  bit win[$];

  always @(posedge clk or negedge rst_n) begin : model
    bit x;
    bit kh_old;
    bit all_diff;
    if (!rst_n) begin
      m_cyc   = 0;
      m_h     = -1000;
      m_lvl   = 1'b0;
      m_kh    = 1'b0;
      m_short = 1'b0;
      m_long  = 1'b0;
      m_rep   = 1'b0;
      pipe    = '{1'b0, 1'b0};
      win.delete();
    end else begin
      m_cyc++;
      x = pipe.pop_front();
      pipe.push_back(key);
      kh_old = m_kh;
      m_kh   = m_lvl;
      win.push_back(x);
      if (win.size() > D) void'(win.pop_front());
      all_diff = (win.size() == D);
      foreach (win[i]) if (win[i] == m_lvl) all_diff = 1'b0;
      if (all_diff) m_lvl = !m_lvl;
      if (m_kh && !kh_old) m_h = m_cyc;
      m_short = kh_old && !m_kh && (m_cyc - m_h < L);
      m_long  = kh_old && (m_cyc == m_h + L);
      m_rep   = AR && kh_old && m_kh && (m_cyc > m_h + L) && ((m_cyc - m_h - L) % R == 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("model_outs", int'({key_held, short_pulse, long_pulse, repeat_pulse}),
            int'({m_kh, m_short, m_long, m_rep}));
      check("pulse_excl", int'((int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse)) > 1), 0);
    end
  end

  int cyc_tb = 0;
  int n_short, n_long, n_rep, rise_at, long_at;
  bit held_seen, prev_held;
  int rep_at[$];

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_rep = 0;
    rise_at = -1; long_at = -1; held_seen = 1'b0;
    rep_at.delete();
  endtask

  task automatic tick(input bit k);
    key = k;
    @(negedge clk);
    cyc_tb++;
    if (short_pulse) n_short++;
    if (long_pulse) begin n_long++; long_at = cyc_tb; end
    if (repeat_pulse) begin n_rep++; rep_at.push_back(cyc_tb); end
    if (key_held && !prev_held) rise_at = cyc_tb;
    if (key_held) held_seen = 1'b1;
    prev_held = key_held;
  endtask

  typedef struct {
    int hold;
    int exp_short;
    int exp_long;
    int exp_reps;
    int exp_held;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int lat;
    int lv;
    int len;

    vecs[0] = '{hold: 3,  exp_short: 0, exp_long: 0, exp_reps: 0,          exp_held: 0};
    vecs[1] = '{hold: 4,  exp_short: 1, exp_long: 0, exp_reps: 0,          exp_held: 1};
    vecs[2] = '{hold: 10, exp_short: 1, exp_long: 0, exp_reps: 0,          exp_held: 1};
    vecs[3] = '{hold: 19, exp_short: 1, exp_long: 0, exp_reps: 0,          exp_held: 1};
    vecs[4] = '{hold: 20, exp_short: 0, exp_long: 1, exp_reps: 0,          exp_held: 1};
    vecs[5] = '{hold: 21, exp_short: 0, exp_long: 1, exp_reps: 0,          exp_held: 1};
    vecs[6] = '{hold: 25, exp_short: 0, exp_long: 1, exp_reps: 0,          exp_held: 1};
    vecs[7] = '{hold: 26, exp_short: 0, exp_long: 1, exp_reps: AR ? 1 : 0, exp_held: 1};
    vecs[8] = '{hold: 40, exp_short: 0, exp_long: 1, exp_reps: AR ? 3 : 0, exp_held: 1};

    rst_n = 1'b0;
    key   = 1'b0;
    prev_held = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outs", int'({key_held, short_pulse, long_pulse, repeat_pulse}), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Bounce every 2 cycles for 30 cycles.
    clear_counts();
    for (int i = 0; i < 15; i++) repeat (2) tick(i % 2 == 0);
    repeat (20) tick(1'b0);
    check("bounce_held", int'(held_seen), 0);
    check("bounce_pulses", n_short + n_long + n_rep, 0);

    foreach (vecs[i]) begin
      clear_counts();
      repeat (vecs[i].hold) tick(1'b1);
      repeat (35) tick(1'b0);
      check($sformatf("vec%0d_short", vecs[i].hold), n_short, vecs[i].exp_short);
      check($sformatf("vec%0d_long", vecs[i].hold), n_long, vecs[i].exp_long);
      check($sformatf("vec%0d_reps", vecs[i].hold), n_rep, vecs[i].exp_reps);
      check($sformatf("vec%0d_held", vecs[i].hold), int'(held_seen), vecs[i].exp_held);
    end

    // Long-press timing relative to key_held and long_pulse.
    clear_counts();
    repeat (40) tick(1'b1);
    repeat (35) tick(1'b0);
    check("long_latency", long_at - rise_at, L);
    check("rep_count", rep_at.size(), AR ? 3 : 0);
    foreach (rep_at[i]) check("rep_offset", rep_at[i] - long_at, R * (i + 1));

    // Reset pulse at press cycle 10 with the key still down.
    clear_counts();
    repeat (10) tick(1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", int'({key_held, short_pulse, long_pulse, repeat_pulse}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = -1;
    for (int i = 1; i <= 80; i++) begin
      tick(1'b1);
      if (long_pulse && lat < 0) lat = i - 1;
    end
    check("reset_relatch_latency", lat, D + 2 + L);
    repeat (35) tick(1'b0);
    check("reset_no_short", n_short, 0);
    check("reset_one_long", n_long, 1);

    // Random key activity, checked cycle by cycle against the model.
    for (int s = 0; s < 80; s++) begin
      lv  = int'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 50));
      repeat (len) tick(lv[0]);
    end
    repeat (40) tick(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
